// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clock out one
// command byte with odd parity, check device ACK, report done/error.
// Ports: clk, rst (async, active-low); tx_valid/tx_data/tx_ready handshake;
// tx_busy, tx_done, tx_err status; ps2_clk_in/ps2_data_in pad levels;
// ps2_clk_oe/ps2_data_oe open-drain pull-low enables.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6500,
  parameter int RTS_CYCLES     = 130,
  parameter int TIMEOUT_CYCLES = 1_300_000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int CMAX = (INHIBIT_CYCLES > RTS_CYCLES)
                      ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FW = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE,
    S_DONE,
    S_ERR
  } state_t;

  state_t         state;
  logic [1:0]     clk_sq;
  logic [1:0]     data_sq;
  logic           clk_s;
  logic           data_s;
  logic           clk_filt;
  logic [FW-1:0]  flt_cnt;
  logic           fall;
  logic [CW-1:0]  cyc;
  logic [TW-1:0]  tmo;
  logic           tmo_hit;
  logic [3:0]     bit_cnt;
  logic [7:0]     sh;
  logic           par;

  assign clk_s    = clk_sq[1];
  assign data_s   = data_sq[1];
  assign tmo_hit  = (tmo == TW'(TIMEOUT_CYCLES - 1));
  assign tx_ready = (state == S_IDLE);
  assign tx_busy  = (state != S_IDLE);

  // Idle bus level is high, so synchronizers reset to 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sq  <= 2'b11;
      data_sq <= 2'b11;
    end else begin
      clk_sq  <= {clk_sq[0], ps2_clk_in};
      data_sq <= {data_sq[0], ps2_data_in};
    end
  end

  // New clock level is taken only after FILTER_LEN differing samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_filt <= 1'b1;
      flt_cnt  <= '0;
      fall     <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_s == clk_filt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_s;
        flt_cnt  <= '0;
        fall     <= clk_filt;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cyc         <= '0;
      tmo         <= '0;
      bit_cnt     <= '0;
      sh          <= '0;
      par         <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          tmo <= '0;
          if (tx_valid) begin
            sh         <= tx_data;
            par        <= ~^tx_data;
            cyc        <= '0;
            ps2_clk_oe <= 1'b1;
            state      <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (cyc == CW'(INHIBIT_CYCLES - 1)) begin
            cyc         <= '0;
            ps2_data_oe <= 1'b1;
            state       <= S_RTS;
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        S_RTS: begin
          if (cyc == CW'(RTS_CYCLES - 1)) begin
            ps2_clk_oe <= 1'b0;
            bit_cnt    <= '0;
            tmo        <= '0;
            state      <= S_SEND;
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        S_SEND: begin
          tmo <= tmo + 1'b1;
          if (tmo_hit) begin
            ps2_data_oe <= 1'b0;
            tx_err      <= 1'b1;
            state       <= S_ERR;
          end else if (fall) begin
            bit_cnt <= bit_cnt + 1'b1;
            unique case (1'b1)
              bit_cnt < 4'd8: begin
                ps2_data_oe <= ~sh[0];
                sh          <= sh >> 1;
              end
              bit_cnt == 4'd8: ps2_data_oe <= ~par;
              default: begin
                ps2_data_oe <= 1'b0;
                state       <= S_ACK;
              end
            endcase
          end
        end
        S_ACK: begin
          tmo <= tmo + 1'b1;
          if (tmo_hit) begin
            tx_err <= 1'b1;
            state  <= S_ERR;
          end else if (fall) begin
            if (!data_s) begin
              state <= S_WAIT_IDLE;
            end else begin
              tx_err <= 1'b1;
              state  <= S_ERR;
            end
          end
        end
        S_WAIT_IDLE: begin
          tmo <= tmo + 1'b1;
          if (tmo_hit) begin
            tx_err <= 1'b1;
            state  <= S_ERR;
          end else if (clk_s && data_s) begin
            tx_done <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_DONE: state <= S_IDLE;
        S_ERR: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a behavioural keyboard model,
// randomized commands, scoreboard checked by an independent monitor.
module tb_ps2_host_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_err;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(20),
    .RTS_CYCLES(4),
    .TIMEOUT_CYCLES(5000),
    .FILTER_LEN(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .tx_ready(tx_ready),
    .tx_busy(tx_busy),
    .tx_done(tx_done),
    .tx_err(tx_err),
    .ps2_clk_in(ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    bit         ok;
  } exp_t;

  exp_t       exp_q[$];
  logic [9:0] obs;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Odd parity: an even number of ones needs a 1 parity bit.
  function automatic bit odd_par(input logic [7:0] d);
    return ($countones(d) % 2) == 0;
  endfunction

  // Frame as the device reads it: d0..d7, parity, stop.
  function automatic logic [9:0] model_frame(input logic [7:0] d);
    logic [9:0] f;
    for (int i = 0; i < 8; i++) f[i] = d[i];
    f[8] = odd_par(d);
    f[9] = 1'b1;
    return f;
  endfunction

  initial begin : monitor
    bit   pd;
    bit   pe;
    exp_t e;
    pd = 0;
    pe = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (pd) check("done_pulse_width", tx_done, 0);
        if (pe) check("err_pulse_width", tx_err, 0);
        if ((tx_done && !pd) || (tx_err && !pe)) begin
          check("done_err_exclusive", tx_done & tx_err, 0);
          check("exp_pending", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("outcome_done", tx_done, e.ok);
            check("lines_released", {ps2_clk_oe, ps2_data_oe}, 0);
            if (e.ok && tx_done)
              check("frame", obs, model_frame(e.data));
          end
        end
        pd = tx_done;
        pe = tx_err;
      end else begin
        pd = 0;
        pe = 0;
      end
    end
  end

  task automatic send(input logic [7:0] d, input bit push,
                      input bit ok, input bit poke);
    int w = 0;
    int n = 0;
    while (!tx_ready && w < 5000) begin
      @(negedge clk);
      w++;
    end
    check("ready_wait", w < 5000, 1);
    if (push) exp_q.push_back('{data: d, ok: ok});
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    check("accept_latency", ps2_clk_oe, 1);
    while (ps2_clk_oe && !ps2_data_oe && n < 1000) begin
      n++;
      if (poke && n < 6) begin
        tx_valid = 1'b1;
        tx_data  = 8'h55;
        check("busy_not_ready", {tx_ready, tx_busy}, 2'b01);
      end else begin
        tx_valid = 1'b0;
      end
      @(negedge clk);
    end
    tx_valid = 1'b0;
    check("inhibit_len", n, 20);
    check("rts_lines", {ps2_clk_oe, ps2_data_oe}, 2'b11);
  endtask

  // Keyboard model: waits for request-to-send, then clocks 11 pulses,
  // reading host data at each rising edge and optionally ACKing.
  task automatic device(input int abort_at, input bit ack,
                        input bit clock_it);
    int w = 0;
    obs = '0;
    while (!(ps2_clk_in && !ps2_data_in) && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check("release_seen", w < 2000, 1);
    if (!clock_it) return;
    repeat (40) @(negedge clk);
    for (int k = 1; k <= 11; k++) begin
      if (k == 11 && ack) dev_data_low = 1'b1;
      dev_clk_low = 1'b1;
      if (k == abort_at) begin
        repeat (20) @(negedge clk);
        return;
      end
      repeat (40) @(negedge clk);
      if (k <= 10) obs[k-1] = ps2_data_in;
      dev_clk_low = 1'b0;
      repeat (40) @(negedge clk);
      if (k == 11) dev_data_low = 1'b0;
    end
  endtask

  initial begin : stim
    int         cnt;
    int         w;
    logic [7:0] d;
    bit         a;

    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    check("rst_ready_busy", {tx_ready, tx_busy}, 2'b10);
    check("rst_done_err", {tx_done, tx_err}, 2'b00);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    send(8'hED, 1, 1, 0);
    device(0, 1, 1);
    send(8'hF4, 1, 1, 0);
    device(0, 1, 1);

    send(8'h3C, 1, 0, 0);
    device(0, 0, 1);

    send(8'($urandom), 1, 0, 0);
    device(0, 0, 0);
    cnt = 0;
    while (!tx_err && cnt < 6000) begin
      @(negedge clk);
      cnt++;
    end
    check("timeout_cycles", cnt, 5000);

    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      a = ($urandom_range(0, 3) != 0);
      send(d, 1, a, 0);
      device(0, a, 1);
    end

    send(8'hA0, 0, 0, 0);
    device(4, 0, 1);
    check("pre_rst_data_oe", ps2_data_oe, 1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    check("async_rst_ready", {tx_ready, tx_busy}, 2'b10);
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    send(8'hFF, 1, 1, 1);
    device(0, 1, 1);

    w = 0;
    while (exp_q.size() != 0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check("scoreboard_drained", exp_q.size(), 0);
    repeat (200) @(negedge clk);
    check("no_queued_send", {ps2_clk_oe, tx_busy}, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
